mod_dec_add_round_key: RTL

- AddRoundKey stage of the AES-256 decryption datapath; sits directly upstream of the decryption InvMixColumns stage.
- Holds all 15 round keys (0..14) in a local key store.
- XORs each incoming 16-byte state with the round key for the current round, counting rounds down from NR to 0.
- Drives the InvMixColumns write enable only on rounds that require InvMixColumns (NR-1 .. 1).

---
 rtl/mod_dec_pkg.sv | 24 ++
 rtl/mod_dec_add_round_key_if.sv | 27 ++
 rtl/mod_dec_round_key_store.sv | 52 +++++
 rtl/mod_dec_add_round_key.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mod_dec_pkg.sv
// Shared types and constants for the AES-256 decryption datapath stages
// (AddRoundKey, InvMixColumns, InvShiftRows).
package mod_dec_pkg;

  localparam int N  = 16;  // bytes per state / round key
  localparam int NR = 14;  // AES-256 rounds; round keys indexed 0..NR

  typedef logic [N-1:0][7:0] state_t;
  typedef logic [3:0]        round_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  localparam round_t ROUND_FIRST = round_t'(NR);
  localparam round_t ROUND_LAST  = round_t'(0);

  // The first decryption round (NR) and the final round (0) skip InvMixColumns.
  function automatic logic needs_inv_mix(input round_t round);
    return (round != ROUND_FIRST) && (round != ROUND_LAST);
  endfunction

endpackage

// File: rtl/mod_dec_add_round_key_if.sv
// State-vector handshake between the upstream stage, AddRoundKey and the
// downstream InvMixColumns stage.
interface mod_dec_add_round_key_if;
  import mod_dec_pkg::*;

  logic   inp_valid;
  logic   inp_ready;
  state_t inp_state;
  logic   outp_valid;
  logic   outp_ready;
  state_t outp_state;
  logic   outp_mc_en;
  logic   outp_last;

  // master: the environment feeding states in and consuming results
  modport master (
    output inp_valid, inp_state, outp_ready,
    input  inp_ready, outp_valid, outp_state, outp_mc_en, outp_last
  );

  // slave: the AddRoundKey stage itself
  modport slave (
    input  inp_valid, inp_state, outp_ready,
    output inp_ready, outp_valid, outp_state, outp_mc_en, outp_last
  );

endinterface

// File: rtl/mod_dec_round_key_store.sv
// Round-key register file (0..NR) with per-entry valid flags, a registered
// all-keys-valid indication and a combinational read port.
module mod_dec_round_key_store
  import mod_dec_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   i_wr_en,
  input  round_t i_wr_idx,
  input  state_t i_wr_data,
  input  logic   i_clear,
  input  round_t i_rd_idx,
  output state_t o_rd_key,
  output logic   o_keys_loaded
);

  state_t      r_key [NR+1];
  logic [NR:0] r_valid;
  logic        r_keys_loaded;
  logic        w_wr_ok;

  // Clear has priority over a same-cycle write; out-of-range indices are dropped.
  assign w_wr_ok = i_wr_en && !i_clear && (i_wr_idx <= ROUND_FIRST);

  // NOTE: the key array has no reset -- its contents are meaningless until the
  // valid bitmap says otherwise, and a reset-free array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_key[i_wr_idx] <= i_wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid       <= '0;
      r_keys_loaded <= 1'b0;
    end else begin
      if (i_clear) begin
        r_valid <= '0;
      end else if (w_wr_ok) begin
        r_valid[i_wr_idx] <= 1'b1;
      end
      r_keys_loaded <= &r_valid;
    end
  end

  assign o_rd_key      = r_key[i_rd_idx];
  assign o_keys_loaded = r_keys_loaded;

endmodule

// File: rtl/mod_dec_add_round_key.sv
// AES-256 decryption AddRoundKey stage: XORs each state with the round key,
// counting rounds NR..0, and flags which results need InvMixColumns.
module mod_dec_add_round_key
  import mod_dec_pkg::*;
(
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         key_wr_en,
  input  round_t                       key_wr_idx,
  input  state_t                       key_wr_data,
  input  logic                         key_clear,
  output logic                         keys_loaded,
  input  logic                         start,
  output logic                         busy,
  mod_dec_add_round_key_if.slave       bus
);

  fsm_t   r_state;
  fsm_t   w_state_nxt;
  round_t r_round;
  round_t w_round_nxt;

  state_t r_outp_state;
  logic   r_outp_valid;
  logic   r_outp_mc_en;
  logic   r_outp_last;

  state_t w_round_key;
  logic   w_keys_loaded;
  logic   w_idle;
  logic   w_inp_ready;
  logic   w_accept;

  assign w_idle = (r_state == IDLE);

  // Key maintenance is only allowed between blocks.
  mod_dec_round_key_store u_key_store (
    .clk           (clk),
    .resetn        (resetn),
    .i_wr_en       (key_wr_en && w_idle),
    .i_wr_idx      (key_wr_idx),
    .i_wr_data     (key_wr_data),
    .i_clear       (key_clear && w_idle),
    .i_rd_idx      (r_round),
    .o_rd_key      (w_round_key),
    .o_keys_loaded (w_keys_loaded)
  );

  assign w_accept = bus.inp_valid && w_inp_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_round <= ROUND_FIRST;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    case (r_state)
      IDLE: begin
        w_round_nxt = ROUND_FIRST;
        if (start && w_keys_loaded) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_accept) begin
          if (r_round == ROUND_LAST) begin
            w_state_nxt = IDLE;
            w_round_nxt = ROUND_FIRST;
          end else begin
            w_round_nxt = r_round - round_t'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_round_nxt = ROUND_FIRST;
      end
    endcase
  end

  always_comb begin
    busy        = (r_state == RUN);
    w_inp_ready = (r_state == RUN) && (!r_outp_valid || bus.outp_ready);
  end

  // A stalled result holds; a drained one clears its flags unless replaced.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_outp_state <= '0;
      r_outp_valid <= 1'b0;
      r_outp_mc_en <= 1'b0;
      r_outp_last  <= 1'b0;
    end else if (w_accept) begin
      r_outp_state <= bus.inp_state ^ w_round_key;
      r_outp_valid <= 1'b1;
      r_outp_mc_en <= needs_inv_mix(r_round);
      r_outp_last  <= (r_round == ROUND_LAST);
    end else if (bus.outp_ready) begin
      r_outp_valid <= 1'b0;
      r_outp_mc_en <= 1'b0;
      r_outp_last  <= 1'b0;
    end
  end

  assign keys_loaded     = w_keys_loaded;
  assign bus.inp_ready   = w_inp_ready;
  assign bus.outp_valid  = r_outp_valid;
  assign bus.outp_state  = r_outp_state;
  assign bus.outp_mc_en  = r_outp_mc_en;
  assign bus.outp_last   = r_outp_last;

endmodule
